sequence_generator: RTL and testbench
=====================================

# sequence_generator

- Transmit side of the 3-bit symbol pattern link.
- On a start request it emits the fixed 8-symbol pattern 001, 101, 110, 000, 110, 110, 011, 101 on a 3-bit bus under a valid/ready handshake.
- Repeats the pattern a programmable number of times, with optional idle gaps between repetitions.
- Drives the pattern-detector input in loopback and stimulus paths.

## Interface

- GAP_CYCLES, default 0: idle cycles (data_valid low) inserted between consecutive repetitions; range 0–255.
- IDLE_SYMBOL, default 3'b111: value driven on data whenever data_valid is low.
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request a burst; sampled only while busy is low.
- repeat_count  input  8  number of pattern repetitions; sampled with an accepted start; 0 treated as 1.
- ready  input  1  downstream accepts the current symbol.
- data  output  3  current symbol.
- data_valid  output  1  data holds a valid pattern symbol.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the last symbol of the burst is accepted.

## Operation

- Reset values, while rst_n is low at a clock edge:
  - data = IDLE_SYMBOL; data_valid = 0; busy = 0; done = 0.
  - FSM = IDLE; all counters cleared.
- FSM states: IDLE, SEND, GAP.
  - IDLE, start=1: latch max(repeat_count,1) into rep_left, sym_idx=0 → SEND.
  - SEND: data_valid=1, data = pattern[sym_idx]. On valid&&ready, sym_idx increments.
    - Acceptance of sym_idx=7 with rep_left>1: decrement rep_left, sym_idx=0, then → GAP (GAP_CYCLES>0) or stay in SEND (GAP_CYCLES=0).
    - Acceptance of sym_idx=7 with rep_left=1: → IDLE and pulse done.
  - GAP: data_valid=0; gap counter counts GAP_CYCLES cycles, then → SEND.
- Handshake rules:
  - data and data_valid are registered outputs.
  - While data_valid=1 and ready=0, data is held stable; no symbol is skipped or repeated.
  - ready is ignored when data_valid=0.
- start while busy=1 is ignored; no queuing.
- busy=1 in SEND and GAP; busy=0 in IDLE, including the cycle done is high.
- start asserted in the done cycle is accepted; the new burst begins the next cycle.
- rst_n low mid-burst aborts the burst: outputs take reset values at that edge, no done pulse.
- Counter widths:
  - sym_idx 3 bits, wraps 7→0.
  - rep_left 8 bits, never decrements below 1.
  - gap counter 8 bits.

## Timing

- start accepted at edge N: data_valid=1 with data=001 from cycle N+1.
- With ready held high, one symbol per cycle: symbol k is visible in cycle N+1+k.
- Total cycles per burst with ready high: R·8 + (R−1)·GAP_CYCLES, where R = max(repeat_count,1).
- done is high in the first cycle after the final acceptance, simultaneous with busy=0 and data_valid=0.
- Each cycle with ready=0 during SEND adds exactly one cycle of latency.

## Configuration

- SEQGEN_ERR_INJECT_EN defined:
  - Adds input err_inject (1 bit), sampled with an accepted start.
  - When latched high, the final symbol of the final repetition is sent as 3'b100 instead of 3'b101; all other symbols are unchanged.
- Undefined: port absent; the pattern is always transmitted uncorrupted.

## Test plan

- Reset, GAP_CYCLES=0, repeat_count=1, ready=1, start at edge N → data 001,101,110,000,110,110,011,101 in cycles N+1..N+8; done=1 and busy=0 in cycle N+9.
- Same burst with ready=0 for 3 cycles while data=000 → 000 held 4 cycles, no symbol lost; done in cycle N+12.
- GAP_CYCLES=2, repeat_count=3, ready=1 → 24 valid symbols, two 2-cycle gaps with data=111 and data_valid=0; done in cycle N+29.
- repeat_count=0 → one repetition only; second start during busy → ignored; start in the done cycle → new burst starts the next cycle.
- rst_n low for one edge while data=110 (symbol 4) → next cycle data=111, data_valid=0, busy=0, done never pulses.
- SEQGEN_ERR_INJECT_EN defined, err_inject=1 with start, repeat_count=2 → the 16th symbol is 100; all other symbols match the pattern.

Source files
------------

// File: rtl/sequence_generator.sv
// sequence_generator
//   Transmit side of the 3-bit symbol pattern link. An accepted start emits
//   the fixed 8-symbol pattern 001,101,110,000,110,110,011,101 under a
//   valid/ready handshake. The pattern is repeated max(repeat_count,1) times,
//   with GAP_CYCLES idle cycles between consecutive repetitions.
//
//   Optional feature macro: SEQGEN_ERR_INJECT_EN
//     Adds input err_inject, sampled with an accepted start. When latched
//     high, the last symbol of the last repetition is sent as 3'b100.
//
// Parameters
//   GAP_CYCLES   idle cycles between repetitions (0..255)
//   IDLE_SYMBOL  value on data while data_valid is low
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   start        burst request, sampled only while busy is low
//   repeat_count repetitions, sampled with an accepted start (0 -> 1)
//   err_inject   (SEQGEN_ERR_INJECT_EN only) corrupt the final symbol
//   ready        downstream accepts the current symbol
//   data         current symbol (registered)
//   data_valid   data holds a pattern symbol (registered)
//   busy         burst in progress (SEND or GAP)
//   done         one-cycle pulse after the final symbol is accepted
module sequence_generator #(
   parameter int         GAP_CYCLES  = 0,
   parameter logic [2:0] IDLE_SYMBOL = 3'b111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] repeat_count,
`ifdef SEQGEN_ERR_INJECT_EN
   input  logic       err_inject,
`endif
   input  logic       ready,
   output logic [2:0] data,
   output logic       data_valid,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   state_t     state;
   logic [2:0] sym_idx;
   logic [7:0] rep_left;
   logic [7:0] gap_cnt;
   logic [2:0] next_sym;

   function automatic logic [2:0] pattern_sym(input logic [2:0] idx);
      case (idx)
         3'd0:    pattern_sym = 3'b001;
         3'd1:    pattern_sym = 3'b101;
         3'd2:    pattern_sym = 3'b110;
         3'd3:    pattern_sym = 3'b000;
         3'd4:    pattern_sym = 3'b110;
         3'd5:    pattern_sym = 3'b110;
         3'd6:    pattern_sym = 3'b011;
         default: pattern_sym = 3'b101;
      endcase
   endfunction

`ifdef SEQGEN_ERR_INJECT_EN
   logic err_lat;

   always_ff @(posedge clk) begin
      if (!rst_n)
         err_lat <= 1'b0;
      else if (state == IDLE && start)
         err_lat <= err_inject;
   end
`endif

   // Symbol to load when the current one is accepted mid-pattern. Because
   // data is registered, the final symbol is chosen one acceptance early,
   // i.e. while sym_idx is 6 on the last repetition.
   always_comb begin
      next_sym = pattern_sym(sym_idx + 3'd1);
`ifdef SEQGEN_ERR_INJECT_EN
      if (err_lat && rep_left == 8'd1 && sym_idx == 3'd6)
         next_sym = 3'b100;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         sym_idx    <= 3'd0;
         rep_left   <= 8'd0;
         gap_cnt    <= 8'd0;
         data       <= IDLE_SYMBOL;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rep_left   <= (repeat_count == 8'd0) ? 8'd1 : repeat_count;
                  sym_idx    <= 3'd0;
                  state      <= SEND;
                  data       <= pattern_sym(3'd0);
                  data_valid <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            SEND: begin
               // data_valid is always high here, so ready alone is acceptance
               if (ready) begin
                  sym_idx <= sym_idx + 3'd1;
                  if (sym_idx == 3'd7) begin
                     if (rep_left > 8'd1) begin
                        rep_left <= rep_left - 8'd1;
                        if (GAP_CYCLES > 0) begin
                           state      <= GAP;
                           gap_cnt    <= 8'd0;
                           data       <= IDLE_SYMBOL;
                           data_valid <= 1'b0;
                        end else begin
                           data <= pattern_sym(3'd0);
                        end
                     end else begin
                        state      <= IDLE;
                        data       <= IDLE_SYMBOL;
                        data_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                     end
                  end else begin
                     data <= next_sym;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + 8'd1;
               if (gap_cnt == GAP_LAST) begin
                  state      <= SEND;
                  data       <= pattern_sym(3'd0);
                  data_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator. Two instances: dut0 with
// GAP_CYCLES=0 and dut2 with GAP_CYCLES=2. Inputs change #1 after a rising
// edge; outputs are sampled at the same point, so "cycle N+k" is the state
// after the k-th edge following the start edge N.
module tb_sequence_generator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, ready0, start2, ready2;
   logic [7:0] rc0, rc2;
   logic       err0, err2;
   logic [2:0] data0, data2;
   logic       valid0, valid2, busy0, busy2, done0, done2;

   int total = 0;
   int bad   = 0;
   logic [2:0] pat [8];

   always #5 clk = ~clk;

   sequence_generator #(.GAP_CYCLES(0), .IDLE_SYMBOL(3'b111)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .repeat_count(rc0),
`ifdef SEQGEN_ERR_INJECT_EN
      .err_inject(err0),
`endif
      .ready(ready0), .data(data0), .data_valid(valid0), .busy(busy0), .done(done0)
   );

   sequence_generator #(.GAP_CYCLES(2), .IDLE_SYMBOL(3'b111)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .repeat_count(rc2),
`ifdef SEQGEN_ERR_INJECT_EN
      .err_inject(err2),
`endif
      .ready(ready2), .data(data2), .data_valid(valid2), .busy(busy2), .done(done2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expects dut0 in a send cycle with symbol d
   task automatic chk0_sym(input string name, input logic [2:0] d);
      total++;
      if (data0 !== d || valid0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0) begin
         bad++;
         $display("FAIL %s: data=%b valid=%b busy=%b done=%b, want data=%b valid=1 busy=1 done=0",
                  name, data0, valid0, busy0, done0, d);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start0 = 0; ready0 = 1; rc0 = 0; err0 = 0;
      start2 = 0; ready2 = 1; rc2 = 0; err2 = 0;
      tick(); tick();
      total++;
      if ({data0, valid0, busy0, done0} !== {3'b111, 3'b000} ||
          {data2, valid2, busy2, done2} !== {3'b111, 3'b000}) begin
         bad++;
         $display("FAIL reset: dut0=%b/%b%b%b dut2=%b/%b%b%b, want 111/000",
                  data0, valid0, busy0, done0, data2, valid2, busy2, done2);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: valid=%b busy=%b done=%b, want 0 0 0", valid0, busy0, done0);
      end
   endtask

   // done cycle of dut0: done=1, busy=0, valid=0, data=idle
   task automatic chk0_done(input string name);
      total++;
      if (done0 !== 1'b1 || busy0 !== 1'b0 || valid0 !== 1'b0 || data0 !== 3'b111) begin
         bad++;
         $display("FAIL %s: done=%b busy=%b valid=%b data=%b, want 1 0 0 111",
                  name, done0, busy0, valid0, data0);
      end
   endtask

   task automatic test_single_burst();
      rc0 = 8'd1; ready0 = 1; start0 = 1;
      tick();                       // edge N
      start0 = 0;
      for (int k = 0; k < 8; k++) begin
         chk0_sym($sformatf("single_sym%0d", k), pat[k]);
         tick();
      end
      chk0_done("single_done");
      tick();
      total++;
      if (done0 !== 1'b0) begin
         bad++;
         $display("FAIL single_done_pulse: done=%b, want 0", done0);
      end
   endtask

   task automatic test_ready_stall();
      int idx;
      rc0 = 8'd1; ready0 = 1; start0 = 1;
      tick();
      start0 = 0;
      for (int c = 1; c <= 11; c++) begin
         ready0 = !(c >= 4 && c <= 6);
         idx = (c < 4) ? c - 1 : (c <= 7) ? 3 : c - 4;
         chk0_sym($sformatf("stall_c%0d", c), pat[idx]);
         tick();
      end
      ready0 = 1;
      chk0_done("stall_done_n12");
      tick();
   endtask

   task automatic test_gap_repeat();
      int p, nvalid;
      nvalid = 0;
      rc2 = 8'd3; ready2 = 1; start2 = 1;
      tick();
      start2 = 0;
      for (int c = 1; c <= 28; c++) begin
         p = (c - 1) % 10;
         total++;
         if (p < 8) begin
            if (data2 !== pat[p] || valid2 !== 1'b1 || busy2 !== 1'b1) begin
               bad++;
               $display("FAIL gap_sym_c%0d: data=%b valid=%b busy=%b, want %b 1 1",
                        c, data2, valid2, busy2, pat[p]);
            end
         end else begin
            if (data2 !== 3'b111 || valid2 !== 1'b0 || busy2 !== 1'b1 || done2 !== 1'b0) begin
               bad++;
               $display("FAIL gap_idle_c%0d: data=%b valid=%b busy=%b done=%b, want 111 0 1 0",
                        c, data2, valid2, busy2, done2);
            end
         end
         if (valid2 === 1'b1) nvalid++;
         tick();
      end
      total++;
      if (nvalid != 24) begin
         bad++;
         $display("FAIL gap_count: valid symbols=%0d, want 24", nvalid);
      end
      total++;
      if (done2 !== 1'b1 || busy2 !== 1'b0 || valid2 !== 1'b0) begin
         bad++;
         $display("FAIL gap_done_n29: done=%b busy=%b valid=%b, want 1 0 0", done2, busy2, valid2);
      end
      tick();
   endtask

   task automatic test_zero_repeat_and_restart();
      rc0 = 8'd0; ready0 = 1; start0 = 1;
      tick();
      start0 = 0;
      for (int k = 0; k < 8; k++) begin
         // request a 5-rep burst mid-way; busy, so it must be ignored
         start0 = (k == 2);
         rc0    = (k == 2) ? 8'd5 : 8'd0;
         chk0_sym($sformatf("zero_sym%0d", k), pat[k]);
         tick();
      end
      start0 = 0;
      chk0_done("zero_done");
      // start in the done cycle
      rc0 = 8'd1; start0 = 1;
      tick();
      start0 = 0;
      for (int k = 0; k < 8; k++) begin
         chk0_sym($sformatf("restart_sym%0d", k), pat[k]);
         tick();
      end
      chk0_done("restart_done");
      tick();
   endtask

   task automatic test_back_to_back();
      rc0 = 8'd2; ready0 = 1; start0 = 1; err0 = 0;
      tick();
      start0 = 0;
      for (int k = 0; k < 16; k++) begin
         chk0_sym($sformatf("b2b_sym%0d", k), pat[k % 8]);
         tick();
      end
      chk0_done("b2b_done");
      tick();
   endtask

   task automatic test_abort();
      int seen_done, seen_valid;
      seen_done = 0; seen_valid = 0;
      rc0 = 8'd1; ready0 = 1; start0 = 1;
      tick();
      start0 = 0;
      tick(); tick(); tick(); tick();   // cycle N+5: symbol 4
      chk0_sym("abort_pre", 3'b110);
      rst_n = 0;
      tick();
      rst_n = 1;
      total++;
      if (data0 !== 3'b111 || valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
         bad++;
         $display("FAIL abort: data=%b valid=%b busy=%b done=%b, want 111 0 0 0",
                  data0, valid0, busy0, done0);
      end
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done0 === 1'b1) seen_done++;
         if (valid0 === 1'b1) seen_valid++;
      end
      total++;
      if (seen_done != 0 || seen_valid != 0) begin
         bad++;
         $display("FAIL abort_quiet: done cycles=%0d valid cycles=%0d, want 0 0", seen_done, seen_valid);
      end
   endtask

`ifdef SEQGEN_ERR_INJECT_EN
   task automatic test_err_inject();
      logic [2:0] exp;
      rc0 = 8'd2; ready0 = 1; start0 = 1; err0 = 1;
      tick();
      start0 = 0; err0 = 0;
      for (int k = 0; k < 16; k++) begin
         exp = (k == 15) ? 3'b100 : pat[k % 8];
         chk0_sym($sformatf("err_sym%0d", k), exp);
         tick();
      end
      chk0_done("err_done");
      tick();
   endtask
`endif

   initial begin
      pat[0] = 3'b001; pat[1] = 3'b101; pat[2] = 3'b110; pat[3] = 3'b000;
      pat[4] = 3'b110; pat[5] = 3'b110; pat[6] = 3'b011; pat[7] = 3'b101;
      test_reset();
      test_single_burst();
      test_ready_stall();
      test_gap_repeat();
      test_zero_repeat_and_restart();
      test_back_to_back();
      test_abort();
`ifdef SEQGEN_ERR_INJECT_EN
      test_err_inject();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
